book_memory_manager: RTL and testbench
======================================

Name: book_memory_manager

Overview:
- Storage stage directly downstream of decrease_order and the other order-book editing engines.
- Holds the sorted book entries for one side of the book.
- Serves single-request read and write transactions over the mem_struct / book_entry / read_result interface, returning a one-cycle mem_valid pulse per transaction.
- Reads return the addressed entry plus its successor, so shift-style deletes and inserts need one read per step.

Parameters:
- DEPTH, 64: number of book_entry slots. Must be ≤ 2^(SIZE_INDEX+1).
- LATENCY, 2: cycles from the start-sampling edge to the mem_valid pulse. Legal range 1..15.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- mem_control  input  mem_struct  {addr, is_write, start}; start is a one-cycle request strobe
- data_w  input  book_entry  write data, sampled on the same edge as start
- mem_valid  output  1  one-cycle completion pulse
- data_r  output  read_result  {first, second} read data
- addr_err  output  1  pulses with mem_valid when the request address was out of range
- busy  output  1  high while a transaction is outstanding

Behaviour:
- Interface decision: one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset values: mem_valid=0, addr_err=0, busy=0, data_r='0, FSM in IDLE, latency counter=0.
- Array contents are not reset; this keeps RAM inference. Book size is tracked upstream.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On a clock edge with mem_control.start=1: latch addr, is_write and data_w; load counter=LATENCY-1; set busy=1; go to BUSY.
  - If LATENCY=1, go directly to RESP instead.
- BUSY: decrement the counter; when it reaches 0, go to RESP.
- RESP (exactly one cycle):
  - Drive mem_valid=1, then return to IDLE and clear busy on the next edge.
  - Timing: start sampled at edge T → mem_valid high during the cycle after edge T+LATENCY-1. The response is never in the same cycle as start.
- Write transaction:
  - The array slot is updated on the edge that enters RESP.
  - data_r holds its previous value.
- Read transaction:
  - data_r.first = entry[addr].
  - data_r.second = entry[addr+1], or '0 if addr+1 ≥ DEPTH.
  - data_r is registered and valid from the mem_valid cycle, held stable until the next read response.
- Read-after-write: a read issued after a write's mem_valid returns the new data. No bypass is needed inside one transaction because only one request is outstanding.
- Out-of-range address (addr ≥ DEPTH):
  - Writes are dropped.
  - Reads return data_r='0.
  - addr_err=1 together with mem_valid.
  - The handshake completes normally.
- start while busy=1 (BUSY or RESP): ignored, and no queueing. Clients must wait for mem_valid.
- start in the same cycle as rst_in: reset wins and the request is lost.
- Reset during BUSY: the transaction is aborted, a pending write is not committed, and no mem_valid is produced.
- Arithmetic: the addr+1 computation is SIZE_INDEX+2 bits wide so that DEPTH-1 does not wrap to slot 0.

Decomposition:
- Shared package (constants.sv) holds book_entry, mem_struct, read_result and the index constants (SIZE_INDEX, PRICE_INDEX, ORDER_INDEX, QUANTITY_INDEX).
- Add BOOK_DEPTH as the shared default for DEPTH.
- Single natural sub-module: book_ram. It is a simple dual-read, single-write register array holding the entry array with two read ports (addr, addr+1).
- The FSM, latency counter and address checks remain in book_memory_manager.

Test Plan:
- Basic write/read, LATENCY=2: write addr 3 = {price 100, id 7, qty 50}, then read addr 3.
  - Expected: first={100,7,50}, second=entry[4].
  - Expected: mem_valid arrives 2 cycles after each start edge and is one cycle wide.
- Successor read:
  - Write addr 5={101,8,10} and addr 6={102,9,20}; read 5 → first={101,8,10}, second={102,9,20}.
  - Read 63 with DEPTH=64 → second='0.
- Out of range: write addr 64 then read addr 64 → addr_err=1 with each mem_valid, data_r='0, slot 0 unchanged.
- Busy rule: second start one cycle after the first → exactly one mem_valid, only the first request's effect visible; busy high throughout.
- Reset mid-write: write addr 2={200,1,5} over old {1,1,1}, assert rst_in during BUSY → no mem_valid; a subsequent read of 2 returns {1,1,1}.
- decrease_order integration, 4 entries with ids 10,11,12,13, delete id 11 → final reads give ids 10,12,13 in slots 0..2, and every handshake completes.

Source files
------------

// File: rtl/book_memory_manager_pkg.sv
// Shared order-book storage types and index constants.
// Imported by the memory manager, its RAM and its bus interface.
package book_memory_manager_pkg;

  localparam int SIZE_INDEX     = 6;
  localparam int PRICE_INDEX    = 15;
  localparam int ORDER_INDEX    = 15;
  localparam int QUANTITY_INDEX = 15;
  localparam int BOOK_DEPTH     = 64;

  typedef struct packed {
    logic [PRICE_INDEX:0]    price;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
  } book_entry;

  typedef struct packed {
    logic [SIZE_INDEX:0] addr;
    logic                is_write;
    logic                start;
  } mem_struct;

  typedef struct packed {
    book_entry first;
    book_entry second;
  } read_result;

endpackage

// File: rtl/book_memory_manager_if.sv
// Request/response bus between book editing engines and storage.
// master = editing engine, slave = book_memory_manager.
interface book_mem_if;
  import book_memory_manager_pkg::*;

  mem_struct  mem_control;
  book_entry  data_w;
  logic       mem_valid;
  read_result data_r;
  logic       addr_err;
  logic       busy;

  modport master (
    output mem_control,
    output data_w,
    input  mem_valid,
    input  data_r,
    input  addr_err,
    input  busy
  );

  modport slave (
    input  mem_control,
    input  data_w,
    output mem_valid,
    output data_r,
    output addr_err,
    output busy
  );

endinterface

// File: rtl/book_memory_manager_ram.sv
// Entry array: one write port, two combinational read ports.
// Contents are not reset so the array can map to RAM.
module book_ram
  import book_memory_manager_pkg::*;
#(
  parameter int DEPTH = BOOK_DEPTH,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  book_entry     wdata,
  input  logic [IW-1:0] raddr_a,
  input  logic [IW-1:0] raddr_b,
  output book_entry     rdata_a,
  output book_entry     rdata_b
);

  book_entry mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/book_memory_manager.sv
// One-side book storage: single outstanding read/write request,
// fixed-latency response, reads return entry and its successor.
module book_memory_manager
  import book_memory_manager_pkg::*;
#(
  parameter int DEPTH   = BOOK_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic      clk_in,
  input  logic      rst_in,
  book_mem_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = SIZE_INDEX + 1;
  localparam int NW = SIZE_INDEX + 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       enter_resp;

  logic [AW-1:0] addr_q;
  logic          wr_q;
  book_entry     wdata_q;

  logic [AW-1:0] cur_addr;
  logic          cur_wr;
  book_entry     cur_data;
  logic [NW-1:0] addr_nx;
  logic          in_rng;
  logic          nx_rng;
  logic          we;

  book_entry  rd_a;
  book_entry  rd_b;
  read_result rd;
  read_result data_q;
  logic       err_q;

  // With LATENCY=1 the commit happens on the start edge itself,
  // so the live request must feed the array instead of the latch.
  always_comb begin
    if (state == IDLE) begin
      cur_addr = bus.mem_control.addr;
      cur_wr   = bus.mem_control.is_write;
      cur_data = bus.data_w;
    end else begin
      cur_addr = addr_q;
      cur_wr   = wr_q;
      cur_data = wdata_q;
    end
  end

  assign addr_nx = NW'(cur_addr) + NW'(1);
  assign in_rng  = NW'(cur_addr) < NW'(DEPTH);
  assign nx_rng  = addr_nx < NW'(DEPTH);
  assign we      = enter_resp & cur_wr & in_rng & ~rst_in;

  book_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk     (clk_in),
    .we      (we),
    .waddr   (cur_addr[IW-1:0]),
    .wdata   (cur_data),
    .raddr_a (cur_addr[IW-1:0]),
    .raddr_b (addr_nx[IW-1:0]),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  always_comb begin
    rd.first  = in_rng ? rd_a : '0;
    rd.second = (in_rng && nx_rng) ? rd_b : '0;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mem_control.start) begin
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = BUSY;
            cnt_n   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n    = RESP;
          enter_resp = 1'b1;
          cnt_n      = 4'd0;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && bus.mem_control.start) begin
        addr_q  <= bus.mem_control.addr;
        wr_q    <= bus.mem_control.is_write;
        wdata_q <= bus.data_w;
      end
      err_q <= enter_resp & ~in_rng;
      if (enter_resp && !cur_wr) begin
        data_q <= rd;
      end
    end
  end

  assign bus.mem_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.data_r    = data_q;
  assign bus.addr_err  = err_q;

endmodule

// File: tb/tb_book_memory_manager.sv
// Scoreboard bench for book_memory_manager (DEPTH=64, LATENCY=2).
// Requests push expected responses; a monitor pops on mem_valid.
module tb_book_memory_manager;
  import book_memory_manager_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int AW    = SIZE_INDEX + 1;

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk = ~clk;

  book_mem_if bus ();

  book_memory_manager #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct packed {
    read_result data;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  book_entry  model [DEPTH];
  read_result last_rd;
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic book_entry mk(int p, int id, int q);
    book_entry b;
    b.price    = 16'(p);
    b.order_id = 16'(id);
    b.quantity = 16'(q);
    return b;
  endfunction

  function automatic read_result exp_read(int a);
    read_result r;
    r = '0;
    if (a < DEPTH) begin
      r.first = model[a];
      if (a + 1 < DEPTH) r.second = model[a+1];
    end
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_in && bus.mem_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got pulse, required none");
      end else begin
        e = sb.pop_front();
        if (bus.data_r !== e.data) begin
          n_fail++;
          $display("FAIL data_r: got %h required %h",
                   bus.data_r, e.data);
        end
        n_cmp++;
        if (bus.addr_err !== e.err) begin
          n_fail++;
          $display("FAIL addr_err: got %b required %b",
                   bus.addr_err, e.err);
        end
      end
    end
  end

  task automatic do_txn(input int a, input logic w,
                        input book_entry d, input logic dup,
                        input int da, input book_entry dd);
    int first_v;
    int pulses;
    logic busy_ok;
    @(negedge clk);
    bus.mem_control.addr     = AW'(a);
    bus.mem_control.is_write = w;
    bus.mem_control.start    = 1'b1;
    bus.data_w               = d;
    if (w) begin
      if (a < DEPTH) model[a] = d;
    end else begin
      last_rd = exp_read(a);
    end
    sb.push_back('{data: last_rd, err: (a >= DEPTH)});
    @(posedge clk);
    #1;
    if (dup) begin
      bus.mem_control.addr     = AW'(da);
      bus.mem_control.is_write = 1'b1;
      bus.data_w               = dd;
    end else begin
      bus.mem_control.start = 1'b0;
    end
    first_v = 0;
    pulses  = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clk);
      if (n == 2) bus.mem_control.start = 1'b0;
      if (bus.mem_valid === 1'b1) begin
        pulses++;
        if (first_v == 0) first_v = n;
      end
      if (n <= LAT && bus.busy !== 1'b1) busy_ok = 1'b0;
      if (n > LAT && bus.busy !== 1'b0) busy_ok = 1'b0;
    end
    n_cmp++;
    if (first_v != LAT) begin
      n_fail++;
      $display("FAIL latency a=%0d: got %0d required %0d",
               a, first_v, LAT);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL pulse_count a=%0d: got %0d required 1",
               a, pulses);
    end
    n_cmp++;
    if (busy_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_window a=%0d: got bad required ok", a);
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.mem_control = '0;
    bus.data_w      = '0;
    rst_in          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_valid, bus.addr_err, bus.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000",
               {bus.mem_valid, bus.addr_err, bus.busy});
    end
    n_cmp++;
    if (bus.data_r !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", bus.data_r);
    end
    // start together with reset is lost
    bus.mem_control = '{addr: AW'(1), is_write: 1'b0, start: 1'b1};
    @(posedge clk);
    #1;
    bus.mem_control.start = 1'b0;
    rst_in = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL start_in_reset: got %0d active cycles required 0",
               bad);
    end
    last_rd = '0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(i, 1'b1, mk(i + 1, i + 500, 3 * i), 1'b0, 0, '0);
    end
  endtask

  task automatic test_basic();
    do_txn(3, 1'b1, mk(100, 7, 50), 1'b0, 0, '0);
    do_txn(3, 1'b0, '0, 1'b0, 0, '0);
  endtask

  task automatic test_successor();
    do_txn(5, 1'b1, mk(101, 8, 10), 1'b0, 0, '0);
    do_txn(6, 1'b1, mk(102, 9, 20), 1'b0, 0, '0);
    do_txn(5, 1'b0, '0, 1'b0, 0, '0);
    do_txn(63, 1'b0, '0, 1'b0, 0, '0);
    do_txn(62, 1'b0, '0, 1'b0, 0, '0);
  endtask

  task automatic test_out_of_range();
    do_txn(64, 1'b1, mk(9, 9, 9), 1'b0, 0, '0);
    do_txn(64, 1'b0, '0, 1'b0, 0, '0);
    do_txn(0, 1'b0, '0, 1'b0, 0, '0);
    do_txn(127, 1'b0, '0, 1'b0, 0, '0);
  endtask

  task automatic test_busy_rule();
    do_txn(9, 1'b1, mk(900, 90, 9), 1'b1, 10, mk(1, 2, 3));
    do_txn(9, 1'b0, '0, 1'b0, 0, '0);
    do_txn(10, 1'b0, '0, 1'b0, 0, '0);
  endtask

  task automatic test_reset_mid_write();
    int bad;
    do_txn(2, 1'b1, mk(1, 1, 1), 1'b0, 0, '0);
    @(negedge clk);
    bus.mem_control = '{addr: AW'(2), is_write: 1'b1, start: 1'b1};
    bus.data_w      = mk(200, 1, 5);
    @(posedge clk);
    #1;
    bus.mem_control.start = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_valid: got %0d pulses required 0", bad);
    end
    last_rd = '0;
    do_txn(2, 1'b0, '0, 1'b0, 0, '0);
  endtask

  task automatic test_decrease_order();
    book_entry d;
    logic [15:0] ids [3];
    for (int i = 0; i < 4; i++) begin
      do_txn(i, 1'b1, mk(300 - i, 10 + i, 5 + i), 1'b0, 0, '0);
    end
    // delete id 11 at slot 1 by shifting slots 2..3 down
    for (int i = 1; i < 3; i++) begin
      do_txn(i, 1'b0, '0, 1'b0, 0, '0);
      d = bus.data_r.second;
      do_txn(i, 1'b1, d, 1'b0, 0, '0);
    end
    ids[0] = 16'd10;
    ids[1] = 16'd12;
    ids[2] = 16'd13;
    for (int i = 0; i < 3; i++) begin
      do_txn(i, 1'b0, '0, 1'b0, 0, '0);
      n_cmp++;
      if (bus.data_r.first.order_id !== ids[i]) begin
        n_fail++;
        $display("FAIL delete_slot%0d: got id %0d required %0d",
                 i, bus.data_r.first.order_id, ids[i]);
      end
    end
  endtask

  initial begin
    last_rd = '0;
    test_reset();
    test_fill();
    test_basic();
    test_successor();
    test_out_of_range();
    test_busy_rule();
    test_reset_mid_write();
    test_decrease_order();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
